// File: rtl/uproc_pkg.sv
// Shared uProcessor definitions: opcodes, register codes and program-memory states.
package uproc_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned REG_W    = 2;

  localparam logic [OPCODE_W-1:0] OPCODE_NOP = 4'h0;
  localparam logic [OPCODE_W-1:0] OPCODE_ADD = 4'h1;
  localparam logic [OPCODE_W-1:0] OPCODE_SUB = 4'h2;
  localparam logic [OPCODE_W-1:0] OPCODE_AND = 4'h3;
  localparam logic [OPCODE_W-1:0] OPCODE_OR  = 4'h4;
  localparam logic [OPCODE_W-1:0] OPCODE_XOR = 4'h5;
  localparam logic [OPCODE_W-1:0] OPCODE_NOT = 4'h6;
  localparam logic [OPCODE_W-1:0] OPCODE_LD  = 4'h7;
  localparam logic [OPCODE_W-1:0] OPCODE_ST  = 4'h8;

  localparam logic [REG_W-1:0] R0 = 2'd0;
  localparam logic [REG_W-1:0] R1 = 2'd1;
  localparam logic [REG_W-1:0] R2 = 2'd2;
  localparam logic [REG_W-1:0] R3 = 2'd3;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } pm_state_e;

endpackage

// File: rtl/prog_mem_ctrl_if.sv
// Load-port and fetch-port bundle between loader/core and the program memory.
interface prog_mem_ctrl_if #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned INSTR_W = 6
) ();

  logic               load_start;
  logic               load_end;
  logic               ld_valid;
  logic               ld_ready;
  logic [INSTR_W-1:0] ld_data;
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [INSTR_W-1:0] ins_out;
  logic               ins_valid;
  logic               busy;
  logic [ADDR_W:0]    load_count;
  logic               load_ovf;

  modport master (
    output load_start, load_end, ld_valid, ld_data, fetch_req, fetch_addr,
    input  ld_ready, ins_out, ins_valid, busy, load_count, load_ovf
  );

  modport slave (
    input  load_start, load_end, ld_valid, ld_data, fetch_req, fetch_addr,
    output ld_ready, ins_out, ins_valid, busy, load_count, load_ovf
  );

endinterface

// File: rtl/prog_mem_array.sv
// Program storage: one synchronous write port, one synchronous read port, no reset.
module prog_mem_array #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned INSTR_W = 6
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [INSTR_W-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read port; data holds when not enabled
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/prog_mem_ctrl.sv
// Writable program memory: clears to NOP, accepts a streamed program, serves fetches.
module prog_mem_ctrl
  import uproc_pkg::*;
#(
  parameter int unsigned        ADDR_W    = 5,
  parameter int unsigned        INSTR_W   = 6,
  parameter logic [INSTR_W-1:0] FILL_WORD = INSTR_W'({OPCODE_NOP, R0})
) (
  input  logic            clk,
  input  logic            rst_n,
  prog_mem_ctrl_if.slave  bus
);

  localparam int unsigned       DEPTH = 2 ** ADDR_W;
  localparam int unsigned       CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  pm_state_e          state, state_nxt;
  logic [ADDR_W-1:0]  ptr, ptr_nxt;
  logic               pend, pend_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               ovf, ovf_nxt;
  logic               busy_q, ready_q, valid_q, seen_q;
  logic               we_c, re_c;
  logic [INSTR_W-1:0] wd_c;
  logic [INSTR_W-1:0] rd_data;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  // Next-state, datapath updates and array port controls
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    pend_nxt  = pend;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    we_c      = 1'b0;
    wd_c      = FILL_WORD;
    re_c      = 1'b0;
    case (state)
      ST_CLEAR: begin
        we_c    = 1'b1;
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == LAST) begin
          state_nxt = pend ? ST_LOAD : ST_RUN;
          pend_nxt  = 1'b0;
        end
      end
      ST_LOAD: begin
        wd_c = bus.ld_data;
        if (bus.ld_valid) begin
          we_c    = 1'b1;
          ptr_nxt = ptr + ADDR_W'(1);
          cnt_nxt = cnt + CNT_W'(1);
          // Filling the last entry ends the load; overflow unless the loader also ended it
          if (ptr == LAST) begin
            state_nxt = ST_RUN;
            ovf_nxt   = ~bus.load_end;
          end else if (bus.load_end) begin
            state_nxt = ST_RUN;
          end
        end else if (bus.load_end) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        re_c = bus.fetch_req;
        if (bus.load_start) begin
          state_nxt = ST_CLEAR;
          pend_nxt  = 1'b1;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      pend    <= 1'b0;
      cnt     <= '0;
      ovf     <= 1'b0;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      seen_q  <= 1'b0;
    end else begin
      ptr     <= ptr_nxt;
      pend    <= pend_nxt;
      cnt     <= cnt_nxt;
      ovf     <= ovf_nxt;
      busy_q  <= (state_nxt != ST_RUN);
      ready_q <= (state_nxt == ST_LOAD);
      valid_q <= re_c;
      seen_q  <= seen_q | re_c;
    end
  end

  prog_mem_array #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_array (
    .clk     (clk),
    .we      (we_c),
    .wr_addr (ptr),
    .wr_data (wd_c),
    .rd_en   (re_c),
    .rd_addr (bus.fetch_addr),
    .rd_data (rd_data)
  );

  // The array read register has no reset, so show FILL_WORD until the first fetch lands
  assign bus.ins_out    = seen_q ? rd_data : FILL_WORD;
  assign bus.ins_valid  = valid_q;
  assign bus.busy       = busy_q;
  assign bus.ld_ready   = ready_q;
  assign bus.load_count = cnt;
  assign bus.load_ovf   = ovf;

endmodule

// File: tb/tb_prog_mem_ctrl.sv
// Directed bench for prog_mem_ctrl: fetch vector tables plus load/reset sequences.
module tb_prog_mem_ctrl;
  import uproc_pkg::*;

  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned INSTR_W = 6;
  localparam int unsigned DEPTH   = 32;
  localparam logic [INSTR_W-1:0] NOP_W = {OPCODE_NOP, R0};

  typedef struct {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] exp;
  } fvec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  fvec_t fv[$];

  always #5 clk = ~clk;

  prog_mem_ctrl_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

  prog_mem_ctrl #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [INSTR_W-1:0] w32(input int i);
    return INSTR_W'(i * 5 + 7);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] e);
    fvec_t v;
    v.addr = a;
    v.exp  = e;
    fv.push_back(v);
  endtask

  // Apply the queued fetch vectors back-to-back, one response per cycle
  task automatic run_fetch(input string tag);
    foreach (fv[i]) begin
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = fv[i].addr;
      tick();
      chk($sformatf("%s valid[%0d]", tag, fv[i].addr), 32'(bus.ins_valid), 32'd1);
      chk($sformatf("%s ins[%0d]", tag, fv[i].addr), 32'(bus.ins_out), 32'(fv[i].exp));
    end
    bus.fetch_req = 1'b0;
    tick();
    chk({tag, " valid drop"}, 32'(bus.ins_valid), 32'd0);
    fv.delete();
  endtask

  task automatic wait_ready(input int start_n);
    int n;
    n = start_n;
    while (!bus.ld_ready && n < 100) begin
      tick();
      n++;
    end
    chk("load_start to ld_ready cycles", 32'(n), 32'(DEPTH + 1));
  endtask

  task automatic start_load();
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    wait_ready(1);
  endtask

  task automatic send(input logic v, input logic [INSTR_W-1:0] d, input logic e);
    bus.ld_valid = v;
    bus.ld_data  = d;
    bus.load_end = e;
    tick();
    bus.ld_valid = 1'b0;
    bus.load_end = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic held;
    bus.load_start = 1'b0;
    bus.load_end   = 1'b0;
    bus.ld_valid   = 1'b0;
    bus.ld_data    = '0;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;

    // Reset values
    tick();
    tick();
    chk("rst busy", 32'(bus.busy), 32'd1);
    chk("rst ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("rst ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("rst ins_out", 32'(bus.ins_out), 32'(NOP_W));
    chk("rst load_count", 32'(bus.load_count), 32'd0);
    chk("rst load_ovf", 32'(bus.load_ovf), 32'd0);

    // Clear takes DEPTH cycles after release
    rst_n = 1'b1;
    held = 1'b1;
    for (int i = 0; i < DEPTH - 1; i++) begin
      tick();
      held = held & bus.busy;
    end
    chk("busy through clear", 32'(held), 32'd1);
    tick();
    chk("busy after clear", 32'(bus.busy), 32'd0);
    chk("ld_ready after clear", 32'(bus.ld_ready), 32'd0);

    // Every entry reads NOP
    for (int a = 0; a < DEPTH; a++) add_vec(ADDR_W'(a), NOP_W);
    run_fetch("clear");

    // Short program with load_end on last word
    start_load();
    send(1'b1, {OPCODE_ADD, R1}, 1'b0);
    send(1'b1, {OPCODE_SUB, R1}, 1'b0);
    send(1'b1, {OPCODE_ST, R3}, 1'b1);
    chk("short load_count", 32'(bus.load_count), 32'd3);
    chk("short load_ovf", 32'(bus.load_ovf), 32'd0);
    chk("short busy", 32'(bus.busy), 32'd0);
    chk("short ld_ready", 32'(bus.ld_ready), 32'd0);
    add_vec(5'd0, {OPCODE_ADD, R1});
    add_vec(5'd1, {OPCODE_SUB, R1});
    add_vec(5'd2, {OPCODE_ST, R3});
    add_vec(5'd3, NOP_W);
    run_fetch("short");

    // Gappy stream: data present while ld_valid is low must not be written
    start_load();
    send(1'b1, {OPCODE_XOR, R2}, 1'b0);
    send(1'b0, 6'h3f, 1'b0);
    send(1'b1, {OPCODE_LD, R0}, 1'b0);
    send(1'b0, 6'h3e, 1'b0);
    send(1'b1, {OPCODE_NOT, R3}, 1'b0);
    send(1'b0, 6'h3d, 1'b0);
    send(1'b1, {OPCODE_AND, R1}, 1'b0);
    chk("gappy ld_ready mid", 32'(bus.ld_ready), 32'd1);
    send(1'b0, 6'h3c, 1'b0);
    send(1'b1, {OPCODE_OR, R2}, 1'b0);
    send(1'b0, 6'h3b, 1'b1);
    chk("gappy load_count", 32'(bus.load_count), 32'd5);
    chk("gappy busy", 32'(bus.busy), 32'd0);
    add_vec(5'd0, {OPCODE_XOR, R2});
    add_vec(5'd1, {OPCODE_LD, R0});
    add_vec(5'd2, {OPCODE_NOT, R3});
    add_vec(5'd3, {OPCODE_AND, R1});
    add_vec(5'd4, {OPCODE_OR, R2});
    add_vec(5'd5, NOP_W);
    add_vec(5'd6, NOP_W);
    run_fetch("gappy");

    // Full load without load_end overflows and auto-returns to RUN
    start_load();
    for (int i = 0; i < DEPTH; i++) begin
      send(1'b1, w32(i), 1'b0);
      if (i == DEPTH - 2) chk("full busy before last", 32'(bus.busy), 32'd1);
    end
    chk("full busy", 32'(bus.busy), 32'd0);
    chk("full ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("full load_ovf", 32'(bus.load_ovf), 32'd1);
    chk("full load_count", 32'(bus.load_count), 32'd32);
    add_vec(5'd0, w32(0));
    add_vec(5'd15, w32(15));
    add_vec(5'd31, w32(31));
    run_fetch("full");

    // load_start with a same-cycle fetch: fetch served from the old program
    bus.load_start = 1'b1;
    bus.fetch_req  = 1'b1;
    bus.fetch_addr = 5'd0;
    tick();
    bus.load_start = 1'b0;
    bus.fetch_req  = 1'b0;
    chk("ls+fetch ins_valid", 32'(bus.ins_valid), 32'd1);
    chk("ls+fetch ins_out", 32'(bus.ins_out), 32'(w32(0)));
    chk("ls+fetch busy", 32'(bus.busy), 32'd1);
    chk("ls clears load_ovf", 32'(bus.load_ovf), 32'd0);
    chk("ls clears load_count", 32'(bus.load_count), 32'd0);
    tick();
    chk("fetch ignored in clear", 32'(bus.ins_valid), 32'd0);
    wait_ready(2);

    // Full load with load_end on the last word: no overflow
    for (int i = 0; i < DEPTH; i++) send(1'b1, w32(DEPTH - 1 - i), (i == DEPTH - 1));
    chk("full+end load_ovf", 32'(bus.load_ovf), 32'd0);
    chk("full+end load_count", 32'(bus.load_count), 32'd32);
    chk("full+end busy", 32'(bus.busy), 32'd0);
    add_vec(5'd0, w32(31));
    add_vec(5'd31, w32(0));
    run_fetch("full+end");

    // Reset mid-load discards the partial program and leaves nothing pending
    start_load();
    send(1'b1, {OPCODE_ADD, R2}, 1'b0);
    send(1'b1, {OPCODE_SUB, R3}, 1'b0);
    chk("pre-rst load_count", 32'(bus.load_count), 32'd2);
    rst_n = 1'b0;
    #2;
    chk("midrst ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("midrst busy", 32'(bus.busy), 32'd1);
    chk("midrst ld_ready", 32'(bus.ld_ready), 32'd0);
    chk("midrst load_count", 32'(bus.load_count), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();
    chk("post-rst busy", 32'(bus.busy), 32'd0);
    chk("post-rst no pending load", 32'(bus.ld_ready), 32'd0);
    add_vec(5'd0, NOP_W);
    add_vec(5'd1, NOP_W);
    run_fetch("post-rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
